mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 16-input, 16-bit mux among 16 requesters.
- Drives the mux 4-bit select and a one-hot grant vector back to the requesters.
- Presents a valid/ready handshake to the single downstream consumer of the mux output.
- Holds ownership for a bounded burst of beats, then rotates priority so no requester starves.

---
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbitration for a shared 16:1 x 16-bit mux with burst-bounded ownership.
// Latency: request-to-grant 1 cycle; owner handover has no bubble (new sel/gnt on the release edge).
// Backpressure: out_ready=0 stalls the owner (beat count and grant hold); the owner withdrawing releases at once.
module mux_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        out_valid,
  output logic        beat_done,
  output logic        burst_last,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         last_q, last_d;
  logic [15:0]        gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               withdraw;
  logic               release_now;
  logic [15:0]        arb_req;
  logic [3:0]         arb_from;
  logic               arb_found;
  logic [3:0]         arb_idx;

  // Handshake view of the registered owner against the live request vector.
  always_comb begin
    busy        = (state_q == GRANT);
    out_valid   = (|gnt_q) & req[sel_q];
    beat_done   = out_valid & out_ready;
    burst_last  = beat_done & (cnt_q == CNT_W'(MAX_BURST - 1));
    withdraw    = busy & ~req[sel_q];
    release_now = busy & (burst_last | withdraw);
  end

  // Arbitration inputs: from IDLE search after last; on release search after the owner,
  // dropping the owner's bit only when it withdrew (a finished burst may re-win if alone).
  always_comb begin
    arb_req  = req;
    arb_from = last_q;
    if (busy) begin
      arb_from = sel_q;
      if (withdraw) begin
        arb_req = req & ~(16'(1) << sel_q);
      end
    end
  end

  // Rotating priority search: first set bit after arb_from, wrapping, arb_from itself last.
  always_comb begin
    logic [3:0] idx;
    arb_found = 1'b0;
    arb_idx   = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      idx = arb_from + 4'(k);
      if (!arb_found && arb_req[idx]) begin
        arb_found = 1'b1;
        arb_idx   = idx;
      end
    end
  end

  // Next-state: grant from IDLE, count beats while owned, hand over or drop on release.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = 16'd0;
        if (arb_found) begin
          sel_d   = arb_idx;
          gnt_d   = 16'(1) << arb_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_d = sel_q;
          cnt_d  = '0;
          if (arb_found) begin
            sel_d = arb_idx;
            gnt_d = 16'(1) << arb_idx;
          end else begin
            gnt_d   = 16'd0;
            state_d = IDLE;
          end
        end else if (beat_done) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'd0;
      end
    endcase
  end

  // State registers; last resets to 15 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
      last_q  <= 4'hF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = sel_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (bursts of 4 and of 1) share stimulus.
// A behavioural owner/priority model predicts every output each cycle.
// Directed scenarios first, then randomized requests, readiness and resets.
module tb_mux_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      req = 16'd0;
  logic             out_ready = 1'b0;

  logic [1:0][3:0]  sel_o;
  logic [1:0][15:0] gnt_o;
  logic [1:0]       valid_o, done_o, last_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: owner index (-1 = nobody), sel value, last owner, beats taken.
  int m_owner[2];
  int m_sel[2];
  int m_last[2];
  int m_cnt[2];
  int mb[2] = '{4, 1};

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[0]), .gnt(gnt_o[0]), .out_valid(valid_o[0]), .beat_done(done_o[0]),
    .burst_last(last_o[0]), .busy(busy_o[0]));

  mux_rr_arbiter #(.MAX_BURST(1), .CNT_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[1]), .gnt(gnt_o[1]), .out_valid(valid_o[1]), .beat_done(done_o[1]),
    .burst_last(last_o[1]), .busy(busy_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // First requester in round-robin order after 'after', wrapping; 'after' itself is tried last.
  function automatic int pick(input logic [15:0] r, input int after);
    for (int k = 1; k <= 16; k++) begin
      if (r[(after + k) % 16]) return (after + k) % 16;
    end
    return -1;
  endfunction

  function automatic bit m_valid(input int i);
    return (m_owner[i] >= 0) && req[m_owner[i]];
  endfunction

  function automatic bit m_last_beat(input int i);
    return m_valid(i) && out_ready && (m_cnt[i] == mb[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_sel[i]   = 0;
      m_last[i]  = 15;
      m_cnt[i]   = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int w;
    logic [15:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        w = pick(req, m_last[i]);
        if (w >= 0) begin
          m_owner[i] = w; m_sel[i] = w; m_cnt[i] = 0;
        end
      end else if (m_last_beat(i) || !req[m_owner[i]]) begin
        r = req;
        if (!req[m_owner[i]]) r[m_owner[i]] = 1'b0;
        m_last[i] = m_owner[i];
        w = pick(r, m_last[i]);
        m_cnt[i] = 0;
        if (w >= 0) begin
          m_owner[i] = w; m_sel[i] = w;
        end else begin
          m_owner[i] = -1;
        end
      end else if (m_valid(i) && out_ready) begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic check_model();
    logic [15:0] eg;
    for (int i = 0; i < 2; i++) begin
      eg = (m_owner[i] < 0) ? 16'd0 : (16'(1) << m_owner[i]);
      chk($sformatf("gnt%0d", i),   32'(gnt_o[i]),   32'(eg));
      chk($sformatf("sel%0d", i),   32'(sel_o[i]),   32'(m_sel[i]));
      chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_valid(i)));
      chk($sformatf("done%0d", i),  32'(done_o[i]),  32'(m_valid(i) && out_ready));
      chk($sformatf("blast%0d", i), 32'(last_o[i]),  32'(m_last_beat(i)));
      chk($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(m_owner[i] >= 0));
    end
  endtask

  // One cycle: clock edge, model update, drive new inputs, then compare away from the edge.
  task automatic cyc(input logic [15:0] r, input logic rd, input logic rs);
    @(posedge clk);
    model_step();
    #1;
    req       = r;
    out_ready = rd;
    rst_n     = rs;
    if (!rs) model_reset();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    cyc(16'h0, 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int nbl;
    logic [6:0] pat;
    logic [15:0] rr;
    model_reset();

    // Reset state.
    do_reset();
    chk("rst_gnt", 32'(gnt_o[0]), 32'h0);
    chk("rst_sel", 32'(sel_o[0]), 32'h0);

    // Lone requester 0: grant after one cycle, burst_last every 4th beat, gnt never drops.
    cyc(16'h0001, 1'b1, 1'b1);
    chk("t1_idle", 32'(gnt_o[0]), 32'h0);
    nbl = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(16'h0001, 1'b1, 1'b1);
      chk("t1_gnt", 32'(gnt_o[0]), 32'h1);
      nbl += int'(last_o[0]);
    end
    chk("t1_nbl", 32'(nbl), 32'd2);

    // All requesting: owners rotate 0..15 with 4 beats each (1 beat each for instance b).
    do_reset();
    cyc(16'hFFFF, 1'b1, 1'b1);
    for (int k = 0; k < 64; k++) begin
      cyc(16'hFFFF, 1'b1, 1'b1);
      chk("t2_sel_a", 32'(sel_o[0]), 32'((k / 4) % 16));
      chk("t2_sel_b", 32'(sel_o[1]), 32'(k % 16));
    end

    // Requester 5 with stalls: 4th accepted beat lands on the 7th cycle.
    do_reset();
    cyc(16'h0020, 1'b1, 1'b1);
    pat = 7'b1011001;
    for (int k = 0; k < 7; k++) begin
      cyc(16'h0020, pat[k], 1'b1);
      chk("t3_gnt", 32'(gnt_o[0]), 32'h20);
      chk("t3_blast", 32'(last_o[0]), 32'(k == 6));
    end

    // Owner 4 withdraws at beat 2: valid falls at once, requester 8 takes over next cycle.
    do_reset();
    cyc(16'h0110, 1'b1, 1'b1);
    cyc(16'h0110, 1'b1, 1'b1);
    chk("t4_sel4", 32'(sel_o[0]), 32'd4);
    cyc(16'h0110, 1'b1, 1'b1);
    cyc(16'h0100, 1'b1, 1'b1);
    chk("t4_valid", 32'(valid_o[0]), 32'd0);
    cyc(16'h0100, 1'b1, 1'b1);
    chk("t4_sel8", 32'(sel_o[0]), 32'd8);
    chk("t4_gnt8", 32'(gnt_o[0]), 32'h100);

    // Reset in the middle of owner 2's burst, then re-grant from the reset priority.
    do_reset();
    cyc(16'h0804, 1'b1, 1'b1);
    cyc(16'h0804, 1'b1, 1'b1);
    cyc(16'h0804, 1'b1, 1'b1);
    cyc(16'h0804, 1'b1, 1'b0);
    chk("t5_gnt0", 32'(gnt_o[0]), 32'h0);
    chk("t5_sel0", 32'(sel_o[0]), 32'h0);
    chk("t5_busy", 32'(busy_o[0]), 32'h0);
    cyc(16'h0804, 1'b1, 1'b1);
    cyc(16'h0804, 1'b1, 1'b1);
    chk("t5_sel2", 32'(sel_o[0]), 32'd2);

    // Single-beat bursts: owners 0 and 15 alternate every cycle.
    do_reset();
    cyc(16'h8001, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(16'h8001, 1'b1, 1'b1);
      chk("t6_sel_b", 32'(sel_o[1]), (k % 2) ? 32'd15 : 32'd0);
      chk("t6_blast_b", 32'(last_o[1]), 32'd1);
    end

    // Randomized traffic: sticky sparse requests, random readiness, rare resets.
    rr = 16'h0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) rr[$urandom_range(0, 15)] = 1'b0;
      cyc(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
